fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives ProgCounter and registers InstrIn into a one-entry InstrOut/PCOut stage.
// Latency: one edge from capture to InstrValid=1. Backpressure: InstrReady=0 holds the stage and the PC. Option: FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
    parameter logic [9:0]  RESET_PC  = 10'd0,
    parameter logic [31:0] HALT_WORD = 32'h0000000C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Run,
    output logic [9:0]  ProgCounter,
    input  logic [31:0] InstrIn,
    output logic [31:0] InstrOut,
    output logic [9:0]  PCOut,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        RedirectEn,
    input  logic [9:0]  RedirectPC,
    output logic        Halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_HALT  = 2'b10
    } state_t;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_DETECT = 1'b1;
`else
    localparam bit HALT_DETECT = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_pc;
    logic [31:0] r_instr;
    logic [9:0]  r_pc_out;
    logic        r_vld;

    logic        w_transfer;
    logic        w_capture;
    logic        w_halt_hit;

    assign w_transfer = r_vld & InstrReady;
    // The stage refills only when empty or draining this cycle; a redirect discards InstrIn.
    assign w_capture  = (r_state == S_FETCH) & ~RedirectEn & (~r_vld | w_transfer);
    assign w_halt_hit = HALT_DETECT && w_capture && (InstrIn == HALT_WORD);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Run)        w_state_nxt = S_FETCH;
            S_FETCH: if (w_halt_hit) w_state_nxt = S_HALT;
            S_HALT:  if (RedirectEn) w_state_nxt = S_FETCH;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_pc_out <= 10'd0;
            r_vld    <= 1'b0;
        end else if (RedirectEn) begin
            // A transfer in the same cycle still completes; the stage just is not refilled.
            r_pc  <= RedirectPC;
            r_vld <= 1'b0;
        end else if (w_capture) begin
            r_instr  <= InstrIn;
            r_pc_out <= r_pc;
            r_vld    <= 1'b1;
            r_pc     <= r_pc + 10'd1;
        end else if (w_transfer) begin
            r_vld <= 1'b0;
        end
    end

    assign ProgCounter = r_pc;
    assign InstrOut    = r_instr;
    assign PCOut       = r_pc_out;
    assign InstrValid  = r_vld;
    assign Halted      = HALT_DETECT && (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: startup, stall, redirect, wrap, halt word and async reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        Run;
    logic [9:0]  ProgCounter;
    logic [31:0] InstrIn;
    logic [31:0] InstrOut;
    logic [9:0]  PCOut;
    logic        InstrValid;
    logic        InstrReady;
    logic        RedirectEn;
    logic [9:0]  RedirectPC;
    logic        Halted;

    logic [31:0] mem [0:1023];
    int          n_cmp;
    int          n_err;

    fetch_sequencer #(
        .RESET_PC  (10'd0),
        .HALT_WORD (32'h0000000C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Run         (Run),
        .ProgCounter (ProgCounter),
        .InstrIn     (InstrIn),
        .InstrOut    (InstrOut),
        .PCOut       (PCOut),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .RedirectEn  (RedirectEn),
        .RedirectPC  (RedirectPC),
        .Halted      (Halted)
    );

    assign InstrIn = mem[ProgCounter];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Run = 1'b0; InstrReady = 1'b0; RedirectEn = 1'b0; RedirectPC = 10'd0;
        #3;
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut, ProgCounter, Halted} !== 54'd0) begin
            n_err++;
            $display("FAIL reset_values: got vld=%0b pcout=%0d instr=%h pc=%0d halted=%0b, want all 0",
                     InstrValid, PCOut, InstrOut, ProgCounter, Halted);
        end
        #4 rst_n = 1'b1;
        step();
        n_cmp++;
        if ({InstrValid, ProgCounter} !== 11'd0) begin
            n_err++;
            $display("FAIL idle_no_fetch: got vld=%0b pc=%0d, want 0/0", InstrValid, ProgCounter);
        end
        RedirectEn = 1'b1; RedirectPC = 10'd50;
        step();
        RedirectEn = 1'b0;
        n_cmp++;
        if ({InstrValid, ProgCounter} !== {1'b0, 10'd50}) begin
            n_err++;
            $display("FAIL idle_redirect: got vld=%0b pc=%0d, want 0/50", InstrValid, ProgCounter);
        end
        step();
        n_cmp++;
        if ({InstrValid, ProgCounter} !== {1'b0, 10'd50}) begin
            n_err++;
            $display("FAIL idle_redirect_stays: got vld=%0b pc=%0d, want 0/50", InstrValid, ProgCounter);
        end
        RedirectEn = 1'b1; RedirectPC = 10'd0;
        step();
        RedirectEn = 1'b0;
    endtask

    task automatic test_startup_and_stall();
        Run = 1'b1; InstrReady = 1'b1;
        step();
        Run = 1'b0;
        n_cmp++;
        if ({InstrValid, ProgCounter} !== 11'd0) begin
            n_err++;
            $display("FAIL run_latency: got vld=%0b pc=%0d, want 0/0", InstrValid, ProgCounter);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({InstrValid, PCOut, InstrOut, ProgCounter} !== {1'b1, 10'(i), 32'(i), 10'(i + 1)}) begin
                n_err++;
                $display("FAIL stream_%0d: got vld=%0b pcout=%0d instr=%h pc=%0d, want 1/%0d/%h/%0d",
                         i, InstrValid, PCOut, InstrOut, ProgCounter, i, i, i + 1);
            end
        end
        InstrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({InstrValid, PCOut, InstrOut, ProgCounter} !== {1'b1, 10'd5, 32'd5, 10'd6}) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got vld=%0b pcout=%0d instr=%h pc=%0d, want 1/5/5/6",
                         i, InstrValid, PCOut, InstrOut, ProgCounter);
            end
        end
        InstrReady = 1'b1;
        for (int i = 6; i < 8; i++) begin
            step();
            n_cmp++;
            if ({InstrValid, PCOut, InstrOut} !== {1'b1, 10'(i), 32'(i)}) begin
                n_err++;
                $display("FAIL release_%0d: got vld=%0b pcout=%0d instr=%h, want 1/%0d/%0d",
                         i, InstrValid, PCOut, InstrOut, i, i);
            end
        end
    endtask

    task automatic test_redirect_stalled();
        InstrReady = 1'b0;
        step();
        n_cmp++;
        if ({InstrValid, PCOut, ProgCounter} !== {1'b1, 10'd7, 10'd8}) begin
            n_err++;
            $display("FAIL stall_at_7: got vld=%0b pcout=%0d pc=%0d, want 1/7/8", InstrValid, PCOut, ProgCounter);
        end
        RedirectEn = 1'b1; RedirectPC = 10'd200;
        step();
        RedirectEn = 1'b0;
        n_cmp++;
        if ({InstrValid, ProgCounter} !== {1'b0, 10'd200}) begin
            n_err++;
            $display("FAIL redirect_flush: got vld=%0b pc=%0d, want 0/200", InstrValid, ProgCounter);
        end
        InstrReady = 1'b1;
        step();
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut, ProgCounter} !== {1'b1, 10'd200, 32'd200, 10'd201}) begin
            n_err++;
            $display("FAIL redirect_target: got vld=%0b pcout=%0d instr=%h pc=%0d, want 1/200/c8/201",
                     InstrValid, PCOut, InstrOut, ProgCounter);
        end
    endtask

    task automatic test_redirect_transfer_wrap();
        logic [9:0] e;
        RedirectEn = 1'b1; RedirectPC = 10'd1022;
        step();
        RedirectEn = 1'b0;
        n_cmp++;
        if ({InstrValid, ProgCounter} !== {1'b0, 10'd1022}) begin
            n_err++;
            $display("FAIL redirect_with_transfer: got vld=%0b pc=%0d, want 0/1022", InstrValid, ProgCounter);
        end
        e = 10'd1022;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({InstrValid, PCOut, ProgCounter} !== {1'b1, e, 10'(e + 10'd1)}) begin
                n_err++;
                $display("FAIL wrap_%0d: got vld=%0b pcout=%0d pc=%0d, want 1/%0d/%0d",
                         i, InstrValid, PCOut, ProgCounter, e, 10'(e + 10'd1));
            end
            e = e + 10'd1;
        end
    endtask

    task automatic test_halt_word();
        mem[3] = 32'h0000000C;
        RedirectEn = 1'b1; RedirectPC = 10'd0;
        step();
        RedirectEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({InstrValid, PCOut, InstrOut} !== {1'b1, 10'(i), mem[i]}) begin
                n_err++;
                $display("FAIL halt_seq_%0d: got vld=%0b pcout=%0d instr=%h, want 1/%0d/%h",
                         i, InstrValid, PCOut, InstrOut, i, mem[i]);
            end
        end
`ifdef FETCH_HALT_DETECT_EN
        n_cmp++;
        if ({Halted, ProgCounter} !== {1'b1, 10'd4}) begin
            n_err++;
            $display("FAIL halt_enter: got halted=%0b pc=%0d, want 1/4", Halted, ProgCounter);
        end
        step();
        n_cmp++;
        if ({Halted, InstrValid, ProgCounter} !== {1'b1, 1'b0, 10'd4}) begin
            n_err++;
            $display("FAIL halt_frozen: got halted=%0b vld=%0b pc=%0d, want 1/0/4", Halted, InstrValid, ProgCounter);
        end
        RedirectEn = 1'b1; RedirectPC = 10'd0;
        step();
        RedirectEn = 1'b0;
        n_cmp++;
        if ({Halted, InstrValid, ProgCounter} !== {1'b0, 1'b0, 10'd0}) begin
            n_err++;
            $display("FAIL halt_exit: got halted=%0b vld=%0b pc=%0d, want 0/0/0", Halted, InstrValid, ProgCounter);
        end
        step();
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut} !== {1'b1, 10'd0, 32'd0}) begin
            n_err++;
            $display("FAIL halt_refetch: got vld=%0b pcout=%0d instr=%h, want 1/0/0", InstrValid, PCOut, InstrOut);
        end
`else
        n_cmp++;
        if ({Halted, ProgCounter} !== {1'b0, 10'd4}) begin
            n_err++;
            $display("FAIL halt_word_plain: got halted=%0b pc=%0d, want 0/4", Halted, ProgCounter);
        end
        step();
        n_cmp++;
        if ({Halted, InstrValid, PCOut, ProgCounter} !== {1'b0, 1'b1, 10'd4, 10'd5}) begin
            n_err++;
            $display("FAIL halt_word_continue: got halted=%0b vld=%0b pcout=%0d pc=%0d, want 0/1/4/5",
                     Halted, InstrValid, PCOut, ProgCounter);
        end
`endif
        mem[3] = 32'd3;
    endtask

    task automatic test_reset_midstall();
        InstrReady = 1'b1;
        RedirectEn = 1'b1; RedirectPC = 10'd9;
        step();
        RedirectEn = 1'b0;
        step();
        InstrReady = 1'b0;
        step();
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut, ProgCounter} !== {1'b1, 10'd9, 32'd9, 10'd10}) begin
            n_err++;
            $display("FAIL stall_at_9: got vld=%0b pcout=%0d instr=%h pc=%0d, want 1/9/9/10",
                     InstrValid, PCOut, InstrOut, ProgCounter);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut, ProgCounter, Halted} !== 54'd0) begin
            n_err++;
            $display("FAIL async_reset: got vld=%0b pcout=%0d instr=%h pc=%0d halted=%0b, want all 0",
                     InstrValid, PCOut, InstrOut, ProgCounter, Halted);
        end
        #1 rst_n = 1'b1;
        InstrReady = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({InstrValid, ProgCounter} !== 11'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got vld=%0b pc=%0d, want 0/0", InstrValid, ProgCounter);
        end
        Run = 1'b1;
        step();
        Run = 1'b0;
        step();
        n_cmp++;
        if ({InstrValid, PCOut, InstrOut, ProgCounter} !== {1'b1, 10'd0, 32'd0, 10'd1}) begin
            n_err++;
            $display("FAIL post_reset_run: got vld=%0b pcout=%0d instr=%h pc=%0d, want 1/0/0/1",
                     InstrValid, PCOut, InstrOut, ProgCounter);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        test_reset();
        test_startup_and_stall();
        test_redirect_stalled();
        test_redirect_transfer_wrap();
        test_halt_word();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
